// File: rtl/mem_access_if.sv
// mem_access_if: request side and data-memory port of the MEM-stage access controller
interface mem_access_if #(parameter int ADDR_W = 32);
  logic req_valid;
  logic req_is_load;
  logic [2:0] req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] req_wdata;
  logic mem_read;
  logic [1:0] mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic load_valid;
  logic stall;
  logic misalign;
  modport slave (
    input req_valid, req_is_load, req_funct3, req_addr, req_wdata, mem_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata, load_data, load_valid, stall, misalign
  );
  modport master (
    output req_valid, req_is_load, req_funct3, req_addr, req_wdata, mem_rdata,
    input mem_read, mem_write, mem_addr, mem_wdata, load_data, load_valid, stall, misalign
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store requester for a synchronous data SRAM
module mem_access_ctrl #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst_n,
  mem_access_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ_WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [1:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0] f3_q;
  logic [31:0] ld_q;
  logic mis_q;
  logic [1:0] size;
  logic aligned, accept, acc_ld, acc_st, capture;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext;
  always_comb begin
    size = (bus.req_funct3 == 3'b000 || bus.req_funct3 == 3'b100) ? 2'b01 :
           (bus.req_funct3 == 3'b001 || bus.req_funct3 == 3'b101) ? 2'b10 :
           (bus.req_funct3 == 3'b010) ? 2'b11 : 2'b00;
    aligned = size == 2'b01 || (size == 2'b10 && !bus.req_addr[0]) ||
              (size == 2'b11 && bus.req_addr[1:0] == 2'b00);
  end
  // Gating with rst_n keeps the combinational issue path quiet while reset is held
  assign accept = rst_n && bus.req_valid && state != READ_WAIT;
  assign acc_ld = accept && aligned && bus.req_is_load;
  assign acc_st = accept && aligned && !bus.req_is_load;
  assign capture = state == READ_WAIT && cnt == 2'd1;
  always_comb begin
    state_nx = acc_ld ? READ_WAIT : capture ? RESP : state == READ_WAIT ? READ_WAIT : IDLE;
    bus.stall = acc_ld || state == READ_WAIT;
    bus.mem_read = acc_ld || state == READ_WAIT;
    bus.mem_write = acc_st ? size : 2'b00;
    bus.mem_addr = state == READ_WAIT ? addr_q : (acc_ld || acc_st) ? bus.req_addr : '0;
    bus.mem_wdata = !acc_st ? 32'd0 :
                    size == 2'b01 ? {4{bus.req_wdata[7:0]}} :
                    size == 2'b10 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    bus.load_valid = state == RESP;
    bus.load_data = ld_q;
    bus.misalign = mis_q;
  end
  always_comb begin
    lane_b = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    ext = f3_q == 3'b000 ? {{24{lane_b[7]}}, lane_b} :
          f3_q == 3'b100 ? {24'd0, lane_b} :
          f3_q == 3'b001 ? {{16{lane_h[15]}}, lane_h} :
          f3_q == 3'b101 ? {16'd0, lane_h} : bus.mem_rdata;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      addr_q <= '0;
      f3_q <= 3'd0;
      ld_q <= 32'd0;
      mis_q <= 1'b0;
    end else begin
      mis_q <= accept && !aligned;
      if (acc_ld) begin
        cnt <= 2'(RD_LAT);
        addr_q <= bus.req_addr;
        f3_q <= bus.req_funct3;
      end else if (state == READ_WAIT) cnt <= cnt - 2'd1;
      if (capture) ld_q <= ext;
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: vector table, corner sequences and randomized model checks
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_access_if #(.ADDR_W(32)) bus1 ();
  mem_access_if #(.ADDR_W(32)) bus3 ();
  mem_access_ctrl #(.RD_LAT(1), .ADDR_W(32)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mem_access_ctrl #(.RD_LAT(3), .ADDR_W(32)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  typedef struct {
    bit ld;
    logic [2:0] f3;
    logic [31:0] addr, wd, rd;
    bit b2b;
    bit mis;
    logic [1:0] wr;
    logic [31:0] wdata, ldata;
  } vec_t;
  int total = 0;
  int passed = 0;
  bit pend_lv = 0;
  bit pend_mis = 0;
  logic [31:0] pend_ld = 0;
  vec_t tbl[15];
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h, expected %h", n, a, e);
  endtask
  function automatic vec_t mk(bit ld, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, logic [31:0] rd,
                              bit b2b, bit mis, logic [1:0] wr, logic [31:0] wdata, logic [31:0] ldata);
    vec_t r;
    r.ld = ld; r.f3 = f3; r.addr = a; r.wd = wd; r.rd = rd; r.b2b = b2b;
    r.mis = mis; r.wr = wr; r.wdata = wdata; r.ldata = ldata;
    return r;
  endfunction
  // Reference: access size in bytes, alignment by modulo, extraction by shift and mask
  function automatic vec_t model(bit ld, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, logic [31:0] rd, bit b2b);
    vec_t r;
    int sz;
    logic [31:0] mask, v;
    sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 0;
    r.ld = ld; r.f3 = f3; r.addr = a; r.wd = wd; r.rd = rd; r.b2b = b2b;
    r.mis = sz == 0 ? 1'b1 : (a % 32'(sz)) != 0;
    r.wr = sz == 1 ? 2'd1 : sz == 2 ? 2'd2 : 2'd3;
    r.wdata = sz == 1 ? {24'd0, wd[7:0]} * 32'h01010101 : sz == 2 ? {16'd0, wd[15:0]} * 32'h00010001 : wd;
    mask = sz == 4 ? 32'hFFFFFFFF : (32'd1 << (8 * sz)) - 32'd1;
    v = (rd >> (8 * (a % 32'd4))) & mask;
    if ((sz == 1 || sz == 2) && !f3[2] && v[8 * sz - 1]) v = v | ~mask;
    r.ldata = v;
    return r;
  endfunction
  task automatic drive(bit v, bit ld, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, logic [31:0] rd);
    @(negedge clk);
    bus1.req_valid = v;
    bus1.req_is_load = ld;
    bus1.req_funct3 = f3;
    bus1.req_addr = a;
    bus1.req_wdata = wd;
    bus1.mem_rdata = rd;
    #1;
    chk("load_valid", bus1.load_valid, pend_lv);
    if (pend_lv) chk("load_data", bus1.load_data, pend_ld);
    chk("misalign", bus1.misalign, pend_mis);
    pend_lv = 0;
    pend_mis = 0;
  endtask
  task automatic idle();
    drive(1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
    chk("idle_read", bus1.mem_read, 0);
    chk("idle_write", bus1.mem_write, 0);
    chk("idle_stall", bus1.stall, 0);
  endtask
  task automatic txn(vec_t r);
    drive(1'b1, r.ld, r.f3, r.addr, r.wd, $urandom);
    if (r.mis) begin
      chk("mis_read", bus1.mem_read, 0);
      chk("mis_write", bus1.mem_write, 0);
      chk("mis_stall", bus1.stall, 0);
      pend_mis = 1;
    end else if (!r.ld) begin
      chk("st_write", bus1.mem_write, r.wr);
      chk("st_addr", bus1.mem_addr, r.addr);
      chk("st_wdata", bus1.mem_wdata, r.wdata);
      chk("st_read", bus1.mem_read, 0);
      chk("st_stall", bus1.stall, 0);
    end else begin
      chk("ld_read", bus1.mem_read, 1);
      chk("ld_stall", bus1.stall, 1);
      chk("ld_addr", bus1.mem_addr, r.addr);
      chk("ld_write", bus1.mem_write, 0);
      drive(1'b1, r.ld, r.f3, r.addr, r.wd, r.rd);
      chk("wait_read", bus1.mem_read, 1);
      chk("wait_stall", bus1.stall, 1);
      chk("wait_addr", bus1.mem_addr, r.addr);
      pend_lv = 1;
      pend_ld = r.ldata;
    end
  endtask
  task automatic load3(logic [2:0] f3, logic [31:0] a, logic [31:0] rd, logic [31:0] exp);
    @(negedge clk);
    bus3.req_valid = 1; bus3.req_is_load = 1; bus3.req_funct3 = f3; bus3.req_addr = a; bus3.mem_rdata = $urandom;
    #1;
    chk("l3_stall", bus3.stall, 1);
    chk("l3_read", bus3.mem_read, 1);
    chk("l3_addr", bus3.mem_addr, a);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus3.mem_rdata = k == 3 ? rd : $urandom;
      #1;
      chk("l3_wait_stall", bus3.stall, 1);
      chk("l3_wait_addr", bus3.mem_addr, a);
      chk("l3_wait_lv", bus3.load_valid, 0);
    end
    @(negedge clk);
    bus3.req_valid = 0; bus3.mem_rdata = $urandom;
    #1;
    chk("l3_valid", bus3.load_valid, 1);
    chk("l3_data", bus3.load_data, exp);
    chk("l3_stall_done", bus3.stall, 0);
    chk("l3_read_done", bus3.mem_read, 0);
    @(negedge clk);
    #1;
    chk("l3_valid_once", bus3.load_valid, 0);
  endtask
  initial begin
    logic [2:0] good[5];
    logic [2:0] bad[3];
    logic [2:0] f3;
    good = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bad = '{3'd3, 3'd6, 3'd7};
    tbl[0] = mk(0, 3'b000, 32'h1003, 32'h000000A5, 0, 0, 0, 2'd1, 32'hA5A5A5A5, 0);
    tbl[1] = mk(0, 3'b001, 32'h1006, 32'h1234BEEF, 0, 0, 0, 2'd2, 32'hBEEFBEEF, 0);
    tbl[2] = mk(0, 3'b010, 32'h1008, 32'hCAFEF00D, 0, 0, 0, 2'd3, 32'hCAFEF00D, 0);
    tbl[3] = mk(1, 3'b000, 32'h2002, 0, 32'h12F03456, 0, 0, 0, 0, 32'hFFFFFFF0);
    tbl[4] = mk(1, 3'b100, 32'h2002, 0, 32'h12F03456, 0, 0, 0, 0, 32'h000000F0);
    tbl[5] = mk(1, 3'b101, 32'h2002, 0, 32'h12F03456, 0, 0, 0, 0, 32'h000012F0);
    tbl[6] = mk(1, 3'b001, 32'h2000, 0, 32'h12F08456, 0, 0, 0, 0, 32'hFFFF8456);
    tbl[7] = mk(1, 3'b000, 32'h2001, 0, 32'h12F03456, 0, 0, 0, 0, 32'h00000034);
    tbl[8] = mk(1, 3'b010, 32'h2004, 0, 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF);
    tbl[9] = mk(1, 3'b010, 32'h2001, 0, 0, 0, 1, 0, 0, 0);
    tbl[10] = mk(0, 3'b001, 32'h3003, 32'h5555AAAA, 0, 0, 1, 0, 0, 0);
    tbl[11] = mk(1, 3'b011, 32'h2000, 0, 0, 0, 1, 0, 0, 0);
    tbl[12] = mk(1, 3'b100, 32'h4003, 0, 32'h80112233, 1, 0, 0, 0, 32'h00000080);
    tbl[13] = mk(1, 3'b001, 32'h4002, 0, 32'h80112233, 1, 0, 0, 0, 32'hFFFF8011);
    tbl[14] = mk(0, 3'b000, 32'h5000, 32'h0000007F, 0, 0, 0, 2'd1, 32'h7F7F7F7F, 0);
    bus3.req_valid = 0; bus3.req_is_load = 0; bus3.req_funct3 = 0;
    bus3.req_addr = 0; bus3.req_wdata = 0; bus3.mem_rdata = 0;
    bus1.req_valid = 1; bus1.req_is_load = 1; bus1.req_funct3 = 3'b010;
    bus1.req_addr = 32'h100; bus1.req_wdata = 32'h11223344; bus1.mem_rdata = 0;
    #1;
    chk("rst_read", bus1.mem_read, 0);
    chk("rst_stall", bus1.stall, 0);
    chk("rst_lv", bus1.load_valid, 0);
    chk("rst_mis", bus1.misalign, 0);
    chk("rst_ldata", bus1.load_data, 0);
    bus1.req_is_load = 0;
    #1;
    chk("rst_write", bus1.mem_write, 0);
    repeat (2) @(negedge clk);
    bus1.req_valid = 0;
    rst_n = 1;
    idle();
    foreach (tbl[i]) begin
      txn(tbl[i]);
      if (!tbl[i].b2b) idle();
    end
    load3(3'b010, 32'h2004, 32'hDEADBEEF, 32'hDEADBEEF);
    load3(3'b000, 32'h2002, 32'h12F03456, 32'hFFFFFFF0);
    drive(1'b1, 1'b1, 3'b010, 32'h2008, 0, $urandom);
    chk("abort_read", bus1.mem_read, 1);
    drive(1'b1, 1'b1, 3'b010, 32'h2008, 0, 32'h01020304);
    chk("abort_wait", bus1.stall, 1);
    #2 rst_n = 0;
    #1;
    chk("abort_read_clr", bus1.mem_read, 0);
    chk("abort_stall_clr", bus1.stall, 0);
    chk("abort_lv_clr", bus1.load_valid, 0);
    @(negedge clk);
    bus1.req_valid = 0;
    rst_n = 1;
    repeat (3) idle();
    for (int n = 0; n < 300; n++) begin
      f3 = ($urandom % 10 == 0) ? bad[$urandom % 3] : good[$urandom % 5];
      txn(model(1'($urandom), f3, $urandom, $urandom, $urandom, 1'($urandom)));
      if (n % 2 == 1 || $urandom % 2 == 0) idle();
    end
    idle();
    idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
MEM-stage requester that drives the data-memory port (MemREAD, MemWrite, address, write_data) on behalf of load/store instructions.
- Stores: generates byte/half/word write strobes and lane-replicated write data.
- Loads: waits out the synchronous SRAM read latency, stalls the pipeline meanwhile, then extracts, aligns and sign- or zero-extends the returned data.
- Flags misaligned accesses instead of issuing them.

Parameters:
RD_LAT, 1, SRAM read latency in cycles (1..3) from MemREAD assertion to valid mem_rdata.
ADDR_W, 32, address width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  MEM-stage instruction is a load or store this cycle
req_is_load  in  1  1 = load, 0 = store
req_funct3  in  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  ADDR_W  effective address from ALU
req_wdata  in  32  store source register value
mem_read  out  1  drives memory MemREAD
mem_write  out  2  drives memory MemWrite: 00 none, 01 byte, 10 half, 11 word
mem_addr  out  ADDR_W  drives memory address (full byte address)
mem_wdata  out  32  drives memory write_data
mem_rdata  in  32  memory read_data (word containing the address)
load_data  out  32  aligned, extended load result to WB
load_valid  out  1  one-cycle pulse, load_data valid
stall  out  1  freeze IF/ID/EX/MEM stages
misalign  out  1  one-cycle pulse on misaligned request

Behaviour:
Reset (async, rst_n=0):
- state=IDLE; all outputs 0; wait counter=0.
- Reset mid-read abandons the read; no load_valid afterwards.

Alignment check, combinational on req_addr:
- H/HU requires addr[0]=0.
- W requires addr[1:0]=00.
- Any other funct3 value is illegal and is treated as misaligned.

IDLE:
- req_valid & misaligned: pulse misalign next cycle; no memory access; stay IDLE; stall=0.
- req_valid & store, aligned: issue in the same cycle, combinationally.
  - mem_write = size code; mem_addr = req_addr.
  - mem_wdata = lane-replicated data: B → {4{wdata[7:0]}}; H → {2{wdata[15:0]}}; W → wdata.
  - stall=0; stay IDLE.
- req_valid & load, aligned:
  - mem_read=1, mem_addr=req_addr in the same cycle.
  - Latch addr[1:0] and funct3.
  - counter=RD_LAT; go READ_WAIT.
  - stall asserted combinationally in this cycle.

READ_WAIT:
- mem_read=1 and mem_addr held at the latched address; stall=1.
- Counter decrements each cycle. When it reaches 1: capture mem_rdata, go RESP.

RESP:
- load_valid=1 for exactly one cycle; load_data registered.
- Extraction:
  - B/BU: byte at offset addr[1:0], i.e. bits [8*off+7 : 8*off].
  - H/HU: half selected by addr[1].
  - Sign-extend for B/H; zero-extend for BU/HU.
- stall=0; return to IDLE.
- A new req_valid in the RESP cycle is accepted per the IDLE rules (back-to-back loads allowed).

Other rules:
- Outside an active access: mem_read=0, mem_write=00.
- req_valid is ignored while stall=1; the upstream pipeline holds the request stable.
- Total load latency: 1 + RD_LAT cycles from acceptance to load_valid. With RD_LAT=1, the result is 2 cycles after the request.

Test Plan:
1. Reset: hold rst_n=0 with req_valid=1 → mem_read=0, mem_write=00, stall=0, load_valid=0; release → IDLE.
2. Store byte, addr=0x1003, wdata=0x000000A5 → same cycle mem_write=01, mem_addr=0x1003, mem_wdata=0xA5A5A5A5, stall=0.
3. Load byte signed, addr=0x2002, mem_rdata=0x12F0_3456 (byte 2 = 0xF0), RD_LAT=1 → stall high 2 cycles, then load_valid pulse with load_data=0xFFFFFFF0. Repeat with BU → 0x000000F0.
4. Load half HU at addr=0x2002 with same rdata → load_data=0x000012F0. Load word at 0x2004, rdata=0xDEADBEEF, RD_LAT=3 → stall 4 cycles, then load_data=0xDEADBEEF.
5. Misaligned word load at 0x2001 and half store at 0x3003 → misalign pulse, no mem_read/mem_write activity, stall=0.
6. Reset asserted during READ_WAIT → outputs clear immediately; no load_valid after release. Back-to-back loads issued in the RESP cycle → two load_valid pulses, 2 cycles apart with RD_LAT=1.
